// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command-side controller for an external 8-bit combinational ALU. Holds a small
//   register file and executes register-to-register ALU commands accepted over a
//   valid/ready handshake.
//
//   Each command takes two cycles:
//     1. IDLE (accept): the operands and op select are registered.
//     2. EXEC: the ALU result is written back, the flags are captured, and done pulses.
//
//   Optional build macro:
//     ALU_SEQ_CV_CALC_EN  when defined, carry and overflow are computed here from the
//                         registered operands and alu_out, and alu_c/alu_v are ignored.
//                         When undefined, alu_c/alu_v are passed straight through.
//
// Ports:
//   clk, rst_n                       clock (rising edge); asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op, cmd_rd, cmd_rs1, cmd_rs2 op select, destination register, source registers
//   ld_en, ld_addr, ld_data          direct register load (takes priority over commands)
//   alu_a, alu_b, alu_s              registered ALU operands and op select
//   alu_out, alu_z/n/c/v             ALU result and flags
//   done                             one-cycle completion pulse
//   flags                            {z,n,c,v} of the last completed command
//   rd_addr, rd_data                 combinational observation read port
module alu_op_sequencer #(
   parameter int unsigned NREGS = 4,
   parameter int unsigned RA_W  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_op,
   input  logic [RA_W-1:0] cmd_rd,
   input  logic [RA_W-1:0] cmd_rs1,
   input  logic [RA_W-1:0] cmd_rs2,
   input  logic            ld_en,
   input  logic [RA_W-1:0] ld_addr,
   input  logic [7:0]      ld_data,
   output logic [7:0]      alu_a,
   output logic [7:0]      alu_b,
   output logic [2:0]      alu_s,
   input  logic [7:0]      alu_out,
   input  logic            alu_z,
   input  logic            alu_n,
   input  logic            alu_c,
   input  logic            alu_v,
   output logic            done,
   output logic [3:0]      flags,
   input  logic [RA_W-1:0] rd_addr,
   output logic [7:0]      rd_data
);

   typedef enum logic [0:0] {StIdle, StExec} state_e;

   state_e          state_q, state_d;
   logic [7:0]      regfile_q [NREGS];
   logic [7:0]      alu_a_q, alu_b_q;
   logic [2:0]      alu_s_q;
   logic [RA_W-1:0] rd_q;
   logic            done_q;
   logic [3:0]      flags_q;
   logic            accept;
   logic            c_sel, v_sel;

   // ------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------
   assign cmd_ready = (state_q == StIdle) & ~ld_en;
   assign accept    = cmd_valid & cmd_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StExec;
         StExec:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Carry / overflow selection
   // ------------------------------------------------------------------
`ifdef ALU_SEQ_CV_CALC_EN
   logic [8:0] sum9;
   logic       unused_cv;

   assign sum9      = {1'b0, alu_a_q} + {1'b0, alu_b_q};
   assign unused_cv = alu_c ^ alu_v;

   always_comb begin
      c_sel = 1'b0;
      v_sel = 1'b0;
      case (alu_s_q)
         3'b000: begin
            c_sel = sum9[8];
            v_sel = (alu_a_q[7] == alu_b_q[7]) & (alu_out[7] != alu_a_q[7]);
         end
         3'b001: begin
            c_sel = alu_a_q < alu_b_q;  // borrow
            v_sel = (alu_a_q[7] != alu_b_q[7]) & (alu_out[7] != alu_a_q[7]);
         end
         3'b110:  c_sel = alu_a_q[7];
         3'b111:  c_sel = alu_a_q[0];
         default: begin
            c_sel = 1'b0;
            v_sel = 1'b0;
         end
      endcase
   end
`else
   assign c_sel = alu_c;
   assign v_sel = alu_v;
`endif

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   // Writeback in EXEC and loads in IDLE cannot collide: a load seen during
   // EXEC is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regfile_q[i] <= 8'h00;
      end else if (state_q == StExec) begin
         regfile_q[rd_q] <= alu_out;
      end else if (ld_en) begin
         regfile_q[ld_addr] <= ld_data;
      end
   end

   // Operands are sampled at accept, so rd may alias rs1/rs2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_q <= 8'h00;
         alu_b_q <= 8'h00;
         alu_s_q <= 3'b000;
         rd_q    <= '0;
      end else if (accept) begin
         alu_a_q <= regfile_q[cmd_rs1];
         alu_b_q <= regfile_q[cmd_rs2];
         alu_s_q <= cmd_op;
         rd_q    <= cmd_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q  <= 1'b0;
         flags_q <= 4'b0000;
      end else begin
         done_q <= (state_q == StExec);
         if (state_q == StExec) flags_q <= {alu_z, alu_n, c_sel, v_sel};
      end
   end

   assign alu_a   = alu_a_q;
   assign alu_b   = alu_b_q;
   assign alu_s   = alu_s_q;
   assign done    = done_q;
   assign flags   = flags_q;
   assign rd_data = regfile_q[rd_addr];

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side controller that drives the 8-bit combinational ALU: owns a small register file and accepts register-to-register ALU commands over a valid/ready handshake.
- Per command: issues registered operands and op select to the ALU, captures the ALU result and flags, writes the result back, and reports completion.
- Sits between the instruction/control path and the ALU datapath.

Parameters:
- NREGS, 4, number of 8-bit registers; power of 2, minimum 2.
- RA_W, 2, register address width; must equal log2(NREGS).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_op  in  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL1, 111 SHR1
- cmd_rd  in  RA_W  destination register
- cmd_rs1  in  RA_W  source for ALU a
- cmd_rs2  in  RA_W  source for ALU b (ignored by NOT/SHL1/SHR1, still driven)
- ld_en  in  1  direct register load request
- ld_addr  in  RA_W  load address
- ld_data  in  8  load data
- alu_a  out  8  registered ALU operand a
- alu_b  out  8  registered ALU operand b
- alu_s  out  3  registered ALU op select
- alu_out  in  8  ALU result, combinational from alu_a/alu_b/alu_s
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags
- done  out  1  one-cycle completion pulse
- flags  out  4  {z,n,c,v} of the last completed command
- rd_addr  in  RA_W  observation read address
- rd_data  out  8  combinational regfile[rd_addr]

Behaviour:
- Reset (async, rst_n=0): all registers 0x00, state IDLE, alu_a/alu_b/alu_s = 0, flags = 0000, done = 0. cmd_ready follows its IDLE equation immediately.
- FSM states IDLE, EXEC.
- cmd_ready = (state==IDLE) & ~ld_en. Loads take priority over commands.
- IDLE:
  - ld_en=1: regfile[ld_addr] <= ld_data at the edge; no command is accepted.
  - Accept (cmd_valid & cmd_ready): alu_a <= reg[rs1], alu_b <= reg[rs2], alu_s <= cmd_op, latch cmd_rd; go to EXEC.
- EXEC (exactly one cycle, cmd_ready=0, ld_en ignored and dropped): at the next edge:
  - reg[rd] <= alu_out.
  - flags <= {alu_z, alu_n, c, v}; c and v are selected per Optional Feature.
  - done <= 1 for one cycle; return to IDLE.
- Latency:
  - Accept at edge k; result and flags visible, and done=1, in the cycle after edge k+1.
  - Next accept possible at edge k+2. Throughput: 1 command per 2 cycles.
- A dependent command accepted at edge k+2 reads the written-back value; no hazard.
- rd == rs1/rs2 is legal: sources are sampled at accept, destination is written in EXEC.
- alu_a/alu_b/alu_s hold their values outside EXEC; they change only on accept.
- rd_data reflects writes the cycle after the writing edge.
- Reset asserted during EXEC: command aborted; no writeback, no done; all state returns to reset values.
- cmd_* inputs are don't-care while cmd_valid=0.

Optional Feature:
- Macro ALU_SEQ_CV_CALC_EN.
- Defined: c and v are computed locally from the latched alu_a/alu_b and alu_out; alu_c/alu_v are ignored.
  - ADD: c = carry out of 9-bit a+b; v = (a7==b7) & (out7!=a7).
  - SUB: c = borrow (a<b unsigned); v = (a7!=b7) & (out7!=a7).
  - SHL1: c = a7, v = 0.
  - SHR1: c = a0, v = 0.
  - All other ops: c = v = 0.
- Undefined: c = alu_c, v = alu_v, passed through unchanged.

Test Plan:
- Reset: pulse rst_n low mid-idle -> all rd_data 0x00, flags 0000, done 0, cmd_ready 1 with ld_en=0.
- Load r1=0x7F, r2=0x01; ADD rd=3 -> done in the cycle after edge k+1, r3=0x80, z=0, n=1; with EN: c=0, v=1.
- Load r1=0x05; SUB r0=r1-r1 -> r0=0x00, z=1, n=0; with EN: c=0, v=0. Then SUB r2=r0-r1 -> 0xFB, n=1; with EN: c=1.
- Back-to-back with cmd_valid held: load r1=0x81; SHL1 r1=r1 twice -> 0x02 then 0x04, cmd_ready=0 in each EXEC cycle, two done pulses 2 cycles apart; with EN: first c=1, second c=0.
- ld_en=1 with cmd_valid=1 in IDLE -> cmd_ready=0, load written, command accepted the next cycle. ld_en during EXEC -> register unchanged.
- Accept ADD into r3, assert rst_n=0 during EXEC -> no done, r3=0x00, flags 0000.
